// File: rtl/ram_cmd_pkg.sv
// Command encoding shared by the command RAM and anything that builds or decodes its words.
package ram_cmd_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/ram_addr_ctr.sv
// Address register with range check, armed flag and optional wrapping post-increment.
// One instance tracks the write side, another the read side.
module ram_addr_ctr #(
    parameter int WORD      = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [WORD-1:0]              load_val,
    input  logic                         inc,
    output logic [$clog2(MEM_DEPTH)-1:0] addr,
    output logic                         armed,
    output logic                         range_err
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [WORD:0] DEPTH_W = (WORD + 1)'(MEM_DEPTH);
    localparam logic [AW:0]   LAST_W  = (AW + 1)'(MEM_DEPTH - 1);

    logic [AW-1:0] addr_q, addr_d;
    logic          armed_q, armed_d;
    logic [AW:0]   addr_inc;

    // Extra bit on both sides so a depth of exactly 2**WORD still compares correctly.
    assign range_err = load && ({1'b0, load_val} >= DEPTH_W);
    assign addr_inc  = {1'b0, addr_q} + (AW + 1)'(1);

    always_comb begin
        addr_d  = addr_q;
        armed_d = armed_q;
        if (load) begin
            if (range_err) begin
                armed_d = 1'b0;
            end else begin
                addr_d  = load_val[AW-1:0];
                armed_d = 1'b1;
            end
        end else if (inc && armed_q && (AUTO_INC != 0)) begin
            addr_d = (addr_inc > LAST_W) ? '0 : addr_inc[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            armed_q <= armed_d;
        end
    end

    assign addr  = addr_q;
    assign armed = armed_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command RAM behind the SPI slave: decodes 2-bit commands, owns the memory array
// and the registered dout / tx_valid / err outputs.
module spi_ram_burst
    import ram_cmd_pkg::*;
#(
    parameter int WORD      = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD+1:0]   din,
    input  logic              rx_valid,
    output logic [WORD-1:0]   dout,
    output logic              tx_valid,
    output logic              err
);

    localparam int AW = $clog2(MEM_DEPTH);

    cmd_e            cmd;
    logic [WORD-1:0] payload;

    logic [AW-1:0]   wr_addr, rd_addr;
    logic            wr_armed, rd_armed;
    logic            wr_range_err, rd_range_err;
    logic            wr_load, wr_inc, rd_load, rd_inc, mem_we;

    logic [WORD-1:0] dout_q, dout_d;
    logic            tx_valid_q, tx_valid_d;
    logic            err_q, err_d;

    logic [WORD-1:0] mem [MEM_DEPTH];

    assign cmd     = cmd_e'(din[WORD+1:WORD]);
    assign payload = din[WORD-1:0];

    ram_addr_ctr #(
        .WORD      (WORD),
        .MEM_DEPTH (MEM_DEPTH),
        .AUTO_INC  (AUTO_INC)
    ) u_wr_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (wr_load),
        .load_val  (payload),
        .inc       (wr_inc),
        .addr      (wr_addr),
        .armed     (wr_armed),
        .range_err (wr_range_err)
    );

    ram_addr_ctr #(
        .WORD      (WORD),
        .MEM_DEPTH (MEM_DEPTH),
        .AUTO_INC  (AUTO_INC)
    ) u_rd_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_load),
        .load_val  (payload),
        .inc       (rd_inc),
        .addr      (rd_addr),
        .armed     (rd_armed),
        .range_err (rd_range_err)
    );

    always_comb begin
        wr_load    = 1'b0;
        wr_inc     = 1'b0;
        rd_load    = 1'b0;
        rd_inc     = 1'b0;
        mem_we     = 1'b0;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        err_d      = 1'b0;
        if (rx_valid) begin
            case (cmd)
                WR_ADDR: begin
                    wr_load = 1'b1;
                    err_d   = wr_range_err;
                end
                WR_DATA: begin
                    if (wr_armed) begin
                        mem_we = 1'b1;
                        wr_inc = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                RD_ADDR: begin
                    rd_load = 1'b1;
                    err_d   = rd_range_err;
                end
                RD_DATA: begin
                    if (rd_armed) begin
                        dout_d     = mem[rd_addr];
                        tx_valid_d = 1'b1;
                        rd_inc     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // Memory is deliberately not reset; a command arriving with rst is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_addr] <= payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst: a default instance (256 deep, no increment)
// and a 16-deep auto-increment instance, driven with directed command sequences.
module tb_spi_ram_burst;
    import ram_cmd_pkg::*;

    localparam int EV_TX  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_a, rst_b;
    logic [9:0] din_a, din_b;
    logic       rx_valid_a, rx_valid_b;
    logic [7:0] dout_a, dout_b;
    logic       tx_valid_a, tx_valid_b;
    logic       err_a, err_b;

    int   cyc;
    int   checks;
    int   errors;
    exp_t q_a[$];
    exp_t q_b[$];

    spi_ram_burst #(
        .WORD      (8),
        .MEM_DEPTH (256),
        .AUTO_INC  (0)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .din      (din_a),
        .rx_valid (rx_valid_a),
        .dout     (dout_a),
        .tx_valid (tx_valid_a),
        .err      (err_a)
    );

    spi_ram_burst #(
        .WORD      (8),
        .MEM_DEPTH (16),
        .AUTO_INC  (1)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .din      (din_b),
        .rx_valid (rx_valid_b),
        .dout     (dout_b),
        .tx_valid (tx_valid_b),
        .err      (err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Issues one command for one cycle and records the response it should provoke.
    task automatic applyStimulus(input bit sel, input cmd_e cmd, input logic [7:0] pay,
                                 input int exp_kind, input logic [7:0] exp_data);
        exp_t e;
        e.kind = exp_kind;
        e.data = exp_data;
        e.cyc  = cyc + 1;
        if (exp_kind != 0) begin
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        if (sel) begin
            din_b      = {cmd, pay};
            rx_valid_b = 1'b1;
        end else begin
            din_a      = {cmd, pay};
            rx_valid_a = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scoreEvent(input bit sel, input logic tx, input logic er, input logic [7:0] d);
        exp_t  e;
        string tag;
        int    kind;
        tag  = sel ? "b" : "a";
        kind = (tx ? EV_TX : 0) + (er ? EV_ERR : 0);
        if ((sel && q_b.size() == 0) || (!sel && q_a.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event_%s: got kind %0d data 0x%0h, expected no event (cycle %0d)",
                     tag, kind, d, cyc);
        end else begin
            e = sel ? q_b.pop_front() : q_a.pop_front();
            checkOutput({"event_kind_", tag}, kind, e.kind);
            checkOutput({"event_dout_", tag}, int'(d), int'(e.data));
            checkOutput({"event_cycle_", tag}, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (tx_valid_a || err_a) scoreEvent(1'b0, tx_valid_a, err_a, dout_a);
        if (tx_valid_b || err_b) scoreEvent(1'b1, tx_valid_b, err_b, dout_b);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_a      = 1'b1;
        rst_b      = 1'b1;
        din_a      = '0;
        din_b      = '0;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        idle(2);
        rst_a = 1'b0;
        rst_b = 1'b0;

        checkOutput("reset_dout_a", int'(dout_a), 0);
        checkOutput("reset_tx_valid_a", int'(tx_valid_a), 0);
        checkOutput("reset_err_a", int'(err_a), 0);
        checkOutput("reset_dout_b", int'(dout_b), 0);

        // Read with nothing armed: error, dout stays at its reset value.
        applyStimulus(0, RD_DATA, 8'h00, EV_ERR, 8'h00);

        // Basic write then read.
        applyStimulus(0, WR_ADDR, 8'h10, 0, 8'h00);
        applyStimulus(0, WR_DATA, 8'hA5, 0, 8'h00);
        applyStimulus(0, RD_ADDR, 8'h10, 0, 8'h00);
        applyStimulus(0, RD_DATA, 8'h00, EV_TX, 8'hA5);
        idle(2);

        // Read after write, address persistence, write directly followed by read.
        applyStimulus(0, WR_ADDR, 8'h05, 0, 8'h00);
        applyStimulus(0, WR_DATA, 8'h3C, 0, 8'h00);
        applyStimulus(0, RD_ADDR, 8'h05, 0, 8'h00);
        applyStimulus(0, RD_DATA, 8'h00, EV_TX, 8'h3C);
        applyStimulus(0, RD_DATA, 8'h00, EV_TX, 8'h3C);
        applyStimulus(0, WR_DATA, 8'h3D, 0, 8'h00);
        applyStimulus(0, RD_DATA, 8'h00, EV_TX, 8'h3D);
        idle(1);

        // Reset in the same cycle as a write: write dropped, both sides disarmed.
        din_a      = {WR_DATA, 8'h77};
        rx_valid_a = 1'b1;
        rst_a      = 1'b1;
        @(posedge clk);
        #1;
        rst_a      = 1'b0;
        rx_valid_a = 1'b0;
        checkOutput("midburst_reset_dout_a", int'(dout_a), 0);
        applyStimulus(0, WR_DATA, 8'h99, EV_ERR, 8'h00);
        applyStimulus(0, RD_DATA, 8'h00, EV_ERR, 8'h00);
        applyStimulus(0, RD_ADDR, 8'h05, 0, 8'h00);
        applyStimulus(0, RD_DATA, 8'h00, EV_TX, 8'h3D);

        // Top address of a full-depth memory is legal.
        applyStimulus(0, WR_ADDR, 8'hFF, 0, 8'h00);
        applyStimulus(0, WR_DATA, 8'h42, 0, 8'h00);
        applyStimulus(0, RD_ADDR, 8'hFF, 0, 8'h00);
        applyStimulus(0, RD_DATA, 8'h00, EV_TX, 8'h42);
        idle(2);

        // Burst across the wrap point of the 16-deep instance.
        applyStimulus(1, WR_ADDR, 8'd14, 0, 8'h00);
        applyStimulus(1, WR_DATA, 8'h11, 0, 8'h00);
        applyStimulus(1, WR_DATA, 8'h22, 0, 8'h00);
        applyStimulus(1, WR_DATA, 8'h33, 0, 8'h00);
        applyStimulus(1, RD_ADDR, 8'd14, 0, 8'h00);
        applyStimulus(1, RD_DATA, 8'h00, EV_TX, 8'h11);
        applyStimulus(1, RD_DATA, 8'h00, EV_TX, 8'h22);
        applyStimulus(1, RD_DATA, 8'h00, EV_TX, 8'h33);
        applyStimulus(1, RD_ADDR, 8'd0, 0, 8'h00);
        applyStimulus(1, RD_DATA, 8'h00, EV_TX, 8'h33);
        idle(1);

        // Out-of-range address rejects and disarms; the following write is refused.
        applyStimulus(1, WR_ADDR, 8'd2, 0, 8'h00);
        applyStimulus(1, WR_DATA, 8'h5A, 0, 8'h00);
        applyStimulus(1, WR_ADDR, 8'd2, 0, 8'h00);
        applyStimulus(1, WR_ADDR, 8'd20, EV_ERR, 8'h33);
        applyStimulus(1, WR_DATA, 8'h55, EV_ERR, 8'h33);
        applyStimulus(1, RD_ADDR, 8'd2, 0, 8'h00);
        applyStimulus(1, RD_DATA, 8'h00, EV_TX, 8'h5A);
        applyStimulus(1, RD_ADDR, 8'd16, EV_ERR, 8'h5A);
        applyStimulus(1, RD_DATA, 8'h00, EV_ERR, 8'h5A);
        applyStimulus(1, RD_ADDR, 8'd15, 0, 8'h00);
        applyStimulus(1, RD_DATA, 8'h00, EV_TX, 8'h22);
        idle(4);

        checkOutput("pending_events_a", q_a.size(), 0);
        checkOutput("pending_events_b", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised single-port command RAM behind the SPI slave; next generation of the fixed 256x8 command RAM.
- Each accepted word carries a 2-bit command plus a WORD-wide payload: write address, write data, read address or read data.
- New over the previous generation:
  - memory depth is configurable and may be less than 2**WORD;
  - optional address post-increment for burst transfers;
  - explicit error reporting for out-of-range and out-of-sequence commands.

Parameters:
- WORD, 8: data and address payload width in bits.
- MEM_DEPTH, 256: number of words; legal range 2..2**WORD.
- AUTO_INC, 0: when 1, the write and read addresses post-increment after each data command.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- din, input, WORD+2: din[WORD+1:WORD] is the command; din[WORD-1:0] is the payload.
- rx_valid, input, 1: din is valid this cycle; one command per high cycle.
- dout, output, WORD: read data.
- tx_valid, output, 1: dout is valid; one-cycle pulse.
- err, output, 1: command rejected; one-cycle pulse.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - dout=0, tx_valid=0, err=0.
  - Write and read address registers = 0.
  - wr_armed=0, rd_armed=0.
  - Memory contents are not reset.
- Reset priority: rst overrides rx_valid in the same cycle; that command is dropped.
- Commands take effect only on a clk edge with rx_valid=1.
- WR_ADDR (00):
  - payload < MEM_DEPTH: load write address, set wr_armed.
  - otherwise: err=1, clear wr_armed, address unchanged.
- WR_DATA (01):
  - wr_armed=1: mem[wr_addr] <= payload. If AUTO_INC, wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
  - wr_armed=0: err=1, no write.
- RD_ADDR (10): same as WR_ADDR, but loads the read address and controls rd_armed.
- RD_DATA (11):
  - rd_armed=1: dout <= mem[rd_addr] and tx_valid=1 on the next edge (latency 1 cycle). If AUTO_INC, rd_addr post-increments with wrap.
  - rd_armed=0: err=1, tx_valid=0, dout holds.
  - The payload is ignored.
- Output hold and pulses: dout holds its last value between reads. tx_valid and err return to 0 one cycle later unless re-triggered.
- Address persistence:
  - With AUTO_INC=0, addresses persist; repeated data commands hit the same location.
  - Armed flags stay set until reset or a rejected address command.
- Read-during-write: a RD_DATA to the address written by the previous cycle's WR_DATA returns the new data. The memory is a single array and commands are serialized, so there is no simultaneous access.
- Back-to-back commands with rx_valid held high are each accepted, one per cycle.
- Width rule: increment is done in $clog2(MEM_DEPTH)+1 bits, then compared against MEM_DEPTH-1 for wrap. No modulo-2**WORD behaviour.

Decomposition:
- Package ram_cmd_pkg:
  - typedef enum logic [1:0] cmd_e {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11}.
  - CMD_W=2.
  - Shared by the RTL and by the transaction/coverage classes.
- Sub-module ram_addr_ctr, instantiated twice (write, read). Parameters WORD, MEM_DEPTH, AUTO_INC.
  - Inputs: load, load_val, inc.
  - Outputs: addr, armed, range_err.
  - Holds the range check, the armed flag and wrap logic.
- Top level holds command decode, the memory array, and the dout/tx_valid/err registers.

Test Plan:
1. Defaults. After rst, send WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA. Expect dout=0xA5 with tx_valid=1 exactly one cycle after RD_DATA; tx_valid=0 the following cycle.
2. AUTO_INC=1, MEM_DEPTH=16. WR_ADDR 14, then WR_DATA 0x11, 0x22, 0x33 back-to-back. RD_ADDR 14, then RD_DATA x3. Expect 0x11, 0x22, 0x33; the 0x33 read comes from address 0 (wrap).
3. MEM_DEPTH=16. WR_ADDR 20 -> err=1 for one cycle. The following WR_DATA 0x55 -> err=1 and memory is unchanged.
4. After rst, RD_DATA with no prior RD_ADDR -> err=1, tx_valid=0, dout=0.
5. Reset mid-burst: assert rst in the same cycle as a WR_DATA 0x77. Expect no write (a later read of that address returns the prior value). Both armed flags clear; a subsequent WR_DATA -> err=1.
6. Read-after-write: WR_DATA 0x3C to addr 5, then the next cycle RD_ADDR 5, then RD_DATA -> dout=0x3C, tx_valid=1.
